// File: rtl/decode_control_stage_pkg.sv
// ---------------------------------------------------------------------------
// decode_control_stage_pkg
// Shared definitions for the decode-stage control path: opcode and Func7
// encodings, ALU operation codes (ALU_CODE_W bits wide, including the
// M-extension codes), memory/immediate/source/result select codes, the
// registered control bundle, its bubble value and the multi-cycle sequencer
// state type.
// Optional feature macro used by the importing files: RV32M_DECODE_EN.
// ---------------------------------------------------------------------------
package decode_control_stage_pkg;

   localparam int ALU_CODE_W = 5;
   typedef logic [ALU_CODE_W-1:0] alu_code_t;

   localparam alu_code_t ALU_ADD    = 5'd0;
   localparam alu_code_t ALU_SUB    = 5'd1;
   localparam alu_code_t ALU_AND    = 5'd2;
   localparam alu_code_t ALU_OR     = 5'd3;
   localparam alu_code_t ALU_XOR    = 5'd4;
   localparam alu_code_t ALU_SLL    = 5'd5;
   localparam alu_code_t ALU_SRL    = 5'd6;
   localparam alu_code_t ALU_SRA    = 5'd7;
   localparam alu_code_t ALU_SLT    = 5'd8;
   localparam alu_code_t ALU_SLTU   = 5'd9;
   localparam alu_code_t ALU_MUL    = 5'd10;
   localparam alu_code_t ALU_MULH   = 5'd11;
   localparam alu_code_t ALU_MULHSU = 5'd12;
   localparam alu_code_t ALU_MULHU  = 5'd13;
   localparam alu_code_t ALU_DIV    = 5'd14;
   localparam alu_code_t ALU_DIVU   = 5'd15;
   localparam alu_code_t ALU_REM    = 5'd16;
   localparam alu_code_t ALU_REMU   = 5'd17;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   // MEM_Control carries Func3 directly, so these match the load/store Func3.
   localparam logic [2:0] MEM_BYTE  = 3'b000;
   localparam logic [2:0] MEM_HALF  = 3'b001;
   localparam logic [2:0] MEM_WORD  = 3'b010;
   localparam logic [2:0] MEM_BYTEU = 3'b100;
   localparam logic [2:0] MEM_HALFU = 3'b101;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   localparam logic BRANCH_PC  = 1'b0;
   localparam logic BRANCH_REG = 1'b1;
   localparam logic SRCA_REG   = 1'b0;
   localparam logic SRCA_PC    = 1'b1;
   localparam logic SRCB_REG   = 1'b0;
   localparam logic SRCB_IMM   = 1'b1;

   localparam logic [1:0] RESULT_ALU = 2'd0;
   localparam logic [1:0] RESULT_MEM = 2'd1;
   localparam logic [1:0] RESULT_PC4 = 2'd2;
   localparam logic [1:0] RESULT_IMM = 2'd3;

   typedef struct packed {
      logic       reg_w_en;
      logic       mem_w_en;
      logic       jump_en;
      logic       branch_en;
      logic [2:0] mem_control;
      alu_code_t  alu_control;
      logic [2:0] imm_type_sel;
      logic       branch_src_sel;
      logic       alu_srca_sel;
      logic       alu_srcb_sel;
      logic [1:0] result_src_sel;
   } ctrl_bundle_t;

   localparam ctrl_bundle_t CTRL_BUBBLE = '{
      reg_w_en:       1'b0,
      mem_w_en:       1'b0,
      jump_en:        1'b0,
      branch_en:      1'b0,
      mem_control:    MEM_BYTE,
      alu_control:    ALU_ADD,
      imm_type_sel:   IMM_I,
      branch_src_sel: BRANCH_PC,
      alu_srca_sel:   SRCA_REG,
      alu_srcb_sel:   SRCB_REG,
      result_src_sel: RESULT_ALU
   };

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } seq_state_t;

   // Base integer op selected by Func3 (Func7 variants handled by the caller).
   function automatic alu_code_t base_alu(input logic [2:0] func3);
      case (func3)
         3'b000:  return ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic alu_code_t muldiv_alu(input logic [2:0] func3);
      case (func3)
         3'b000:  return ALU_MUL;
         3'b001:  return ALU_MULH;
         3'b010:  return ALU_MULHSU;
         3'b011:  return ALU_MULHU;
         3'b100:  return ALU_DIV;
         3'b101:  return ALU_DIVU;
         3'b110:  return ALU_REM;
         default: return ALU_REMU;
      endcase
   endfunction

   function automatic logic is_muldiv(input alu_code_t code);
      return (code >= ALU_MUL) && (code <= ALU_REMU);
   endfunction

endpackage

// File: rtl/decode_control_stage_control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Combinational RV32I decoder producing the control bundle for one
// instruction, plus an Illegal flag. Illegal encodings return CTRL_BUBBLE.
// Macro RV32M_DECODE_EN: when defined, Func7=0000001 on the R-type opcode
// decodes to the M-extension ALU codes; otherwise those encodings are illegal.
// Ports:
//   Instr   in  32  instruction word
//   Ctrl    out     decoded control bundle
//   Illegal out 1   instruction could not be decoded
// ---------------------------------------------------------------------------
module control_unit
   import decode_control_stage_pkg::*;
(
   input  logic [31:0]  Instr,
   output ctrl_bundle_t Ctrl,
   output logic         Illegal
);

   logic [6:0] opcode;
   logic [2:0] func3;
   logic [6:0] func7;
   logic       unused_fields;

   assign opcode        = Instr[6:0];
   assign func3         = Instr[14:12];
   assign func7         = Instr[31:25];
   assign unused_fields = ^{Instr[24:15], Instr[11:7]};

   always_comb begin
      Ctrl    = CTRL_BUBBLE;
      Illegal = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            Ctrl.reg_w_en = 1'b1;
            if (func7 == F7_BASE)
               Ctrl.alu_control = base_alu(func3);
            else if (func7 == F7_ALT && func3 == 3'b000)
               Ctrl.alu_control = ALU_SUB;
            else if (func7 == F7_ALT && func3 == 3'b101)
               Ctrl.alu_control = ALU_SRA;
`ifdef RV32M_DECODE_EN
            else if (func7 == F7_MULDIV)
               Ctrl.alu_control = muldiv_alu(func3);
`endif
            else
               Illegal = 1'b1;
         end
         OP_IALU: begin
            Ctrl.reg_w_en     = 1'b1;
            Ctrl.alu_srcb_sel = SRCB_IMM;
            Ctrl.alu_control  = base_alu(func3);
            // Shift-immediates reuse Func7 as shamt[11:5]; only two values are legal.
            if (func3 == 3'b001 && func7 != F7_BASE)
               Illegal = 1'b1;
            else if (func3 == 3'b101) begin
               if (func7 == F7_ALT)
                  Ctrl.alu_control = ALU_SRA;
               else if (func7 != F7_BASE)
                  Illegal = 1'b1;
            end
         end
         OP_JALR: begin
            Ctrl.reg_w_en       = 1'b1;
            Ctrl.jump_en        = 1'b1;
            Ctrl.branch_src_sel = BRANCH_REG;
            Ctrl.alu_srcb_sel   = SRCB_IMM;
            Ctrl.result_src_sel = RESULT_PC4;
            Illegal             = (func3 != 3'b000);
         end
         OP_LOAD: begin
            Ctrl.reg_w_en       = 1'b1;
            Ctrl.mem_control    = func3;
            Ctrl.alu_srcb_sel   = SRCB_IMM;
            Ctrl.result_src_sel = RESULT_MEM;
            Illegal = !(func3 inside {MEM_BYTE, MEM_HALF, MEM_WORD, MEM_BYTEU, MEM_HALFU});
         end
         OP_STORE: begin
            Ctrl.mem_w_en     = 1'b1;
            Ctrl.mem_control  = func3;
            Ctrl.imm_type_sel = IMM_S;
            Ctrl.alu_srcb_sel = SRCB_IMM;
            Illegal = !(func3 inside {MEM_BYTE, MEM_HALF, MEM_WORD});
         end
         OP_BRANCH: begin
            // The branch condition travels on MEM_Control; MEM_W_En stays 0.
            Ctrl.branch_en    = 1'b1;
            Ctrl.mem_control  = func3;
            Ctrl.alu_control  = ALU_SUB;
            Ctrl.imm_type_sel = IMM_B;
            Illegal = (func3 == 3'b010) || (func3 == 3'b011);
         end
         OP_AUIPC: begin
            Ctrl.reg_w_en     = 1'b1;
            Ctrl.imm_type_sel = IMM_U;
            Ctrl.alu_srca_sel = SRCA_PC;
            Ctrl.alu_srcb_sel = SRCB_IMM;
         end
         OP_LUI: begin
            Ctrl.reg_w_en       = 1'b1;
            Ctrl.imm_type_sel   = IMM_U;
            Ctrl.result_src_sel = RESULT_IMM;
         end
         OP_JAL: begin
            Ctrl.reg_w_en       = 1'b1;
            Ctrl.jump_en        = 1'b1;
            Ctrl.imm_type_sel   = IMM_J;
            Ctrl.result_src_sel = RESULT_PC4;
         end
         default: Illegal = 1'b1;
      endcase
      if (Illegal)
         Ctrl = CTRL_BUBBLE;
   end

endmodule

// File: rtl/decode_control_stage.sv
// ---------------------------------------------------------------------------
// decode_control_stage
// Decodes the IF/ID instruction and registers the control bundle into the
// ID/EX (E) register with valid tracking, stall/flush handling, illegal
// flagging with a saturating counter, and a multi-cycle issue sequencer for
// M-extension ops.
// Macro RV32M_DECODE_EN: enables M decode and the sequencer; when undefined
// the sequencer is absent and Busy is tied to 0.
// Ports:
//   CLK, RST (sync, active-low)       clock and reset
//   Instr_Valid, Instr[31:0]          IF/ID instruction
//   Stall, Flush                      hazard hold / bubble insert
//   Busy                              sequencer active, front end must hold
//   Valid_E, Illegal_E, *_E           registered E-stage control bundle
//   Illegal_Count[CNT_W-1:0]          saturating illegal-instruction count
// ---------------------------------------------------------------------------
module decode_control_stage
   import decode_control_stage_pkg::*;
#(
   parameter int ALU_CTRL_W = ALU_CODE_W,
   parameter int CNT_W      = 16,
   parameter int MULDIV_LAT = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  Instr_Valid,
   input  logic [31:0]           Instr,
   input  logic                  Stall,
   input  logic                  Flush,
   output logic                  Busy,
   output logic                  Valid_E,
   output logic                  Illegal_E,
   output logic                  REG_W_En_E,
   output logic                  MEM_W_En_E,
   output logic                  Jump_En_E,
   output logic                  Branch_En_E,
   output logic [2:0]            MEM_Control_E,
   output logic [ALU_CTRL_W-1:0] ALU_Control_E,
   output logic [2:0]            Imm_Type_Sel_E,
   output logic                  Branch_Src_Sel_E,
   output logic                  ALU_SrcA_Sel_E,
   output logic                  ALU_SrcB_Sel_E,
   output logic [1:0]            Result_Src_Sel_E,
   output logic [CNT_W-1:0]      Illegal_Count
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   ctrl_bundle_t       dec_ctrl;
   logic               dec_illegal;
   ctrl_bundle_t       e_d, e_q;
   logic               valid_d, valid_q;
   logic               illegal_d, illegal_q;
   logic [CNT_W-1:0]   cnt_d, cnt_q;
   logic               busy;

   control_unit u_control_unit (
      .Instr   (Instr),
      .Ctrl    (dec_ctrl),
      .Illegal (dec_illegal)
   );

   always_comb begin
      e_d       = e_q;
      valid_d   = valid_q;
      illegal_d = illegal_q;
      cnt_d     = cnt_q;
      if (Flush) begin
         e_d       = CTRL_BUBBLE;
         valid_d   = 1'b0;
         illegal_d = 1'b0;
      end else if (Stall || busy) begin
         // hold
      end else if (Instr_Valid) begin
         e_d       = dec_ctrl;
         valid_d   = 1'b1;
         illegal_d = dec_illegal;
         if (dec_illegal)
            cnt_d = sat_inc(cnt_q);
      end else begin
         e_d       = CTRL_BUBBLE;
         valid_d   = 1'b0;
         illegal_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         e_q       <= CTRL_BUBBLE;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         e_q       <= e_d;
         valid_q   <= valid_d;
         illegal_q <= illegal_d;
         cnt_q     <= cnt_d;
      end
   end

`ifdef RV32M_DECODE_EN
   localparam int WAIT_W = $clog2(MULDIV_LAT);

   seq_state_t        state_d, state_q;
   logic [WAIT_W-1:0] wait_d, wait_q;

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      if (Flush) begin
         state_d = IDLE;
         wait_d  = '0;
      end else if (state_q == WAIT) begin
         // Stall does not pause the count; the last decrement returns to IDLE
         // so the posedge after Busy falls can load.
         wait_d = wait_q - 1'b1;
         if (wait_q == WAIT_W'(1))
            state_d = IDLE;
      end else if (!Stall && Instr_Valid && !dec_illegal && is_muldiv(dec_ctrl.alu_control)) begin
         state_d = WAIT;
         wait_d  = WAIT_W'(MULDIV_LAT - 1);
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= IDLE;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   assign busy = (state_q == WAIT);
`else
   localparam int unused_muldiv_lat = MULDIV_LAT;
   assign busy = 1'b0;
`endif

   assign Busy             = busy;
   assign Valid_E          = valid_q;
   assign Illegal_E        = illegal_q;
   assign REG_W_En_E       = e_q.reg_w_en;
   assign MEM_W_En_E       = e_q.mem_w_en;
   assign Jump_En_E        = e_q.jump_en;
   assign Branch_En_E      = e_q.branch_en;
   assign MEM_Control_E    = e_q.mem_control;
   assign ALU_Control_E    = ALU_CTRL_W'(e_q.alu_control);
   assign Imm_Type_Sel_E   = e_q.imm_type_sel;
   assign Branch_Src_Sel_E = e_q.branch_src_sel;
   assign ALU_SrcA_Sel_E   = e_q.alu_srca_sel;
   assign ALU_SrcB_Sel_E   = e_q.alu_srcb_sel;
   assign Result_Src_Sel_E = e_q.result_src_sel;
   assign Illegal_Count    = cnt_q;

endmodule

// File: tb/tb_decode_control_stage.sv
module tb_decode_control_stage;
   import decode_control_stage_pkg::*;

   localparam int LAT = 4;
   localparam logic [31:0] I_SUB   = 32'h408701B3;
   localparam logic [31:0] I_FENCE = 32'h4087018F;
   localparam logic [31:0] I_MUL   = 32'h028701B3;
   localparam logic [31:0] I_JAL   = 32'h408771EF;
   localparam logic [31:0] I_ADD   = 32'h008701B3;

   logic        CLK = 1'b0;
   logic        RST, Instr_Valid, Stall, Flush;
   logic [31:0] Instr;

   logic        Busy, Valid_E, Illegal_E, REG_W_En_E, MEM_W_En_E, Jump_En_E, Branch_En_E;
   logic [2:0]  MEM_Control_E, Imm_Type_Sel_E;
   logic [4:0]  ALU_Control_E;
   logic        Branch_Src_Sel_E, ALU_SrcA_Sel_E, ALU_SrcB_Sel_E;
   logic [1:0]  Result_Src_Sel_E;
   logic [15:0] Illegal_Count;

   logic        s_busy, s_valid, s_ill, s_rw, s_mw, s_j, s_b, s_bs, s_sa, s_sb;
   logic [2:0]  s_mc, s_imm;
   logic [4:0]  s_alu;
   logic [1:0]  s_res;
   logic [1:0]  s_cnt;

   decode_control_stage #(.ALU_CTRL_W(5), .CNT_W(16), .MULDIV_LAT(LAT)) dut (
      .CLK(CLK), .RST(RST), .Instr_Valid(Instr_Valid), .Instr(Instr),
      .Stall(Stall), .Flush(Flush), .Busy(Busy), .Valid_E(Valid_E),
      .Illegal_E(Illegal_E), .REG_W_En_E(REG_W_En_E), .MEM_W_En_E(MEM_W_En_E),
      .Jump_En_E(Jump_En_E), .Branch_En_E(Branch_En_E), .MEM_Control_E(MEM_Control_E),
      .ALU_Control_E(ALU_Control_E), .Imm_Type_Sel_E(Imm_Type_Sel_E),
      .Branch_Src_Sel_E(Branch_Src_Sel_E), .ALU_SrcA_Sel_E(ALU_SrcA_Sel_E),
      .ALU_SrcB_Sel_E(ALU_SrcB_Sel_E), .Result_Src_Sel_E(Result_Src_Sel_E),
      .Illegal_Count(Illegal_Count)
   );

   decode_control_stage #(.ALU_CTRL_W(5), .CNT_W(2), .MULDIV_LAT(LAT)) dut_small (
      .CLK(CLK), .RST(RST), .Instr_Valid(Instr_Valid), .Instr(Instr),
      .Stall(Stall), .Flush(Flush), .Busy(s_busy), .Valid_E(s_valid),
      .Illegal_E(s_ill), .REG_W_En_E(s_rw), .MEM_W_En_E(s_mw),
      .Jump_En_E(s_j), .Branch_En_E(s_b), .MEM_Control_E(s_mc),
      .ALU_Control_E(s_alu), .Imm_Type_Sel_E(s_imm),
      .Branch_Src_Sel_E(s_bs), .ALU_SrcA_Sel_E(s_sa),
      .ALU_SrcB_Sel_E(s_sb), .Result_Src_Sel_E(s_res),
      .Illegal_Count(s_cnt)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;

   // Reference model state
   ctrl_bundle_t m_e;
   bit           m_valid, m_ill;
   int           m_cnt, m_cnt2, m_busy_left;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Decode straight from the ISA rules, table-driven per opcode class.
   function automatic void ref_decode(input logic [31:0] ins, output ctrl_bundle_t c,
                                      output bit ill, output bit mop);
      alu_code_t  base_tab [8];
      alu_code_t  m_tab [8];
      logic [6:0] op, f7;
      logic [2:0] f3;
      base_tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      m_tab    = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
      op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
      c = CTRL_BUBBLE; ill = 0; mop = 0;
      if (op == 7'b0110011) begin
         c.reg_w_en = 1;
         if (f7 == 7'h00) c.alu_control = base_tab[f3];
         else if (f7 == 7'h20 && f3 == 3'd0) c.alu_control = ALU_SUB;
         else if (f7 == 7'h20 && f3 == 3'd5) c.alu_control = ALU_SRA;
`ifdef RV32M_DECODE_EN
         else if (f7 == 7'h01) begin c.alu_control = m_tab[f3]; mop = 1; end
`endif
         else ill = 1;
      end else if (op == 7'b0010011) begin
         c.reg_w_en = 1; c.alu_srcb_sel = SRCB_IMM; c.alu_control = base_tab[f3];
         if (f3 == 3'd1) ill = (f7 != 7'h00);
         if (f3 == 3'd5) begin
            if (f7 == 7'h20) c.alu_control = ALU_SRA;
            else ill = (f7 != 7'h00);
         end
      end else if (op == 7'b1100111) begin
         c.reg_w_en = 1; c.jump_en = 1; c.branch_src_sel = BRANCH_REG;
         c.alu_srcb_sel = SRCB_IMM; c.result_src_sel = RESULT_PC4; ill = (f3 != 0);
      end else if (op == 7'b0000011) begin
         c.reg_w_en = 1; c.mem_control = f3; c.alu_srcb_sel = SRCB_IMM;
         c.result_src_sel = RESULT_MEM; ill = (f3 == 3 || f3 == 6 || f3 == 7);
      end else if (op == 7'b0100011) begin
         c.mem_w_en = 1; c.mem_control = f3; c.imm_type_sel = IMM_S;
         c.alu_srcb_sel = SRCB_IMM; ill = (f3 > 2);
      end else if (op == 7'b1100011) begin
         c.branch_en = 1; c.mem_control = f3; c.alu_control = ALU_SUB;
         c.imm_type_sel = IMM_B; ill = (f3 == 2 || f3 == 3);
      end else if (op == 7'b0010111) begin
         c.reg_w_en = 1; c.imm_type_sel = IMM_U; c.alu_srca_sel = SRCA_PC; c.alu_srcb_sel = SRCB_IMM;
      end else if (op == 7'b0110111) begin
         c.reg_w_en = 1; c.imm_type_sel = IMM_U; c.result_src_sel = RESULT_IMM;
      end else if (op == 7'b1101111) begin
         c.reg_w_en = 1; c.jump_en = 1; c.imm_type_sel = IMM_J; c.result_src_sel = RESULT_PC4;
      end else ill = 1;
      if (ill) c = CTRL_BUBBLE;
   endfunction

   task automatic model_clock();
      ctrl_bundle_t c;
      bit ill, mop;
      if (!RST) begin
         m_e = CTRL_BUBBLE; m_valid = 0; m_ill = 0; m_cnt = 0; m_cnt2 = 0; m_busy_left = 0;
      end else if (Flush) begin
         m_e = CTRL_BUBBLE; m_valid = 0; m_ill = 0; m_busy_left = 0;
      end else if (Stall || m_busy_left > 0) begin
         if (m_busy_left > 0) m_busy_left--;
      end else if (Instr_Valid) begin
         ref_decode(Instr, c, ill, mop);
         m_e = c; m_valid = 1; m_ill = ill;
         if (ill) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
         end
         if (mop) m_busy_left = LAT - 1;
      end else begin
         m_e = CTRL_BUBBLE; m_valid = 0; m_ill = 0;
      end
   endtask

   task automatic check_all();
      ctrl_bundle_t ob;
      ob.reg_w_en = REG_W_En_E; ob.mem_w_en = MEM_W_En_E; ob.jump_en = Jump_En_E;
      ob.branch_en = Branch_En_E; ob.mem_control = MEM_Control_E; ob.alu_control = ALU_Control_E;
      ob.imm_type_sel = Imm_Type_Sel_E; ob.branch_src_sel = Branch_Src_Sel_E;
      ob.alu_srca_sel = ALU_SrcA_Sel_E; ob.alu_srcb_sel = ALU_SrcB_Sel_E;
      ob.result_src_sel = Result_Src_Sel_E;
      check("valid_e", Valid_E, m_valid);
      check("illegal_e", Illegal_E, m_ill);
      check("ctrl_bundle", 32'(ob), 32'(m_e));
      check("busy", Busy, (m_busy_left > 0));
      check("illegal_count", Illegal_Count, m_cnt);
      check("illegal_count_w2", s_cnt, m_cnt2);
   endtask

   task automatic tick();
      @(posedge CLK);
      model_clock();
      #1;
      check_all();
   endtask

   task automatic drive(input logic rst, input logic v, input logic [31:0] ins,
                        input logic st, input logic fl);
      RST = rst; Instr_Valid = v; Instr = ins; Stall = st; Flush = fl;
   endtask

   initial begin
      int busy_cycles;
      int exp_small [5];
      logic [6:0] ops [12];
      logic [6:0] f7s [4];
      logic [31:0] r;
      exp_small = '{1, 2, 3, 3, 3};
      ops = '{7'b0110011, 7'b0010011, 7'b1100111, 7'b0000011, 7'b0100011, 7'b1100011,
              7'b0010111, 7'b0110111, 7'b1101111, 7'b0001111, 7'b1110011, 7'b0000000};
      f7s = '{7'h00, 7'h20, 7'h01, 7'h7f};
      m_e = CTRL_BUBBLE; m_valid = 0; m_ill = 0; m_cnt = 0; m_cnt2 = 0; m_busy_left = 0;

      // Reset state
      drive(0, 1, I_SUB, 0, 0);
      tick(); tick();
      check("rst_valid", Valid_E, 1'b0);
      check("rst_count", Illegal_Count, 16'd0);

      // SUB
      drive(1, 1, I_SUB, 0, 0);
      tick();
      check("sub_alu", ALU_Control_E, ALU_SUB);
      check("sub_regw", REG_W_En_E, 1'b1);

      // FENCE, then held by Stall
      drive(1, 1, I_FENCE, 0, 0);
      tick();
      check("fence_illegal", Illegal_E, 1'b1);
      check("fence_count", Illegal_Count, 16'd1);
      drive(1, 1, I_FENCE, 1, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("fence_stall_count", Illegal_Count, 16'd1);
      end

      // Narrow counter saturation
      drive(0, 0, 32'h0, 0, 0);
      tick();
      drive(1, 1, I_FENCE, 0, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("sat_count_w2", s_cnt, exp_small[i]);
      end

      // MUL
      drive(1, 1, I_MUL, 0, 0);
      tick();
`ifdef RV32M_DECODE_EN
      check("mul_alu", ALU_Control_E, ALU_MUL);
      drive(1, 1, I_ADD, 0, 0);
      busy_cycles = 0;
      while (Busy && busy_cycles < 20) begin
         busy_cycles++;
         check("mul_hold", ALU_Control_E, ALU_MUL);
         tick();
      end
      check("mul_busy_cycles", busy_cycles, LAT - 1);
      tick();
      check("add_after_busy", ALU_Control_E, ALU_ADD);
`else
      check("mul_illegal", Illegal_E, 1'b1);
      check("mul_no_busy", Busy, 1'b0);
`endif

      // Flush beats Stall
      drive(1, 1, I_ADD, 1, 1);
      tick();
      check("flush_valid", Valid_E, 1'b0);

`ifdef RV32M_DECODE_EN
      drive(1, 1, I_MUL, 0, 0);
      tick();
      check("flushwait_busy_on", Busy, 1'b1);
      drive(1, 1, I_MUL, 0, 1);
      tick();
      check("flushwait_busy_off", Busy, 1'b0);
`endif

      // Reset mid-WAIT with JAL pending
      drive(1, 1, I_MUL, 0, 0);
      tick();
      drive(1, 1, I_JAL, 0, 0);
      tick();
      drive(0, 1, I_JAL, 0, 0);
      tick();
      check("rstwait_valid", Valid_E, 1'b0);
      check("rstwait_busy", Busy, 1'b0);
      check("rstwait_count", Illegal_Count, 16'd0);
      drive(1, 1, I_JAL, 0, 0);
      tick();
      check("jal_jump", Jump_En_E, 1'b1);
      check("jal_imm", Imm_Type_Sel_E, IMM_J);
      check("jal_result", Result_Src_Sel_E, RESULT_PC4);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         r = $urandom;
         r[6:0] = ops[$urandom_range(0, 11)];
         if ($urandom_range(0, 3) != 3) r[31:25] = f7s[$urandom_range(0, 3)];
         drive(($urandom_range(0, 99) >= 2), ($urandom_range(0, 9) < 8), r,
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
